// File: rtl/mash_dsm_core.sv
// MASH 1..3 delta-sigma modulator core: cascaded accumulators, registered carry
// cancellation, en-gated sampling and a glitch-free frac-word handshake. Optional dither: MASH_DSM_DITHER_EN.
`timescale 1ns/1ps

module mash_dsm_core #(
  parameter int N     = 16,
  parameter int ORDER = 3,
  parameter int OUT_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [N-1:0]            frac_in,
  input  logic                    frac_valid,
  output logic                    frac_ready,
  output logic [N-1:0]            frac_active,
  output logic signed [OUT_W-1:0] y,
  output logic                    y_valid
);

  localparam int CW = (OUT_W > 4) ? OUT_W : 4;

  if (ORDER < 1 || ORDER > 3) begin : g_bad_order
    $error("mash_dsm_core: ORDER must be 1..3");
  end
  if (ORDER > 1 && OUT_W < 2) begin : g_bad_out_w
    $error("mash_dsm_core: OUT_W must be >= 2 when ORDER > 1");
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;
  logic   w_capture;
  logic   w_apply;
  logic   r_frac_ready;
  logic [N-1:0] r_pend;
  logic [N-1:0] r_frac_active;

  logic [N-1:0]          r_acc   [ORDER];
  logic [N:0]            w_sum   [ORDER];
  logic signed [CW-1:0]  w_d     [ORDER];
  logic signed [CW-1:0]  r_dprev [ORDER];
  logic signed [OUT_W-1:0] r_y;
  logic                  r_y_valid;
  logic                  w_cin;

  function automatic logic signed [CW-1:0] carry_ext(input logic c);
    return {{(CW-1){1'b0}}, c};
  endfunction

`ifdef MASH_DSM_DITHER_EN
  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;

  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_cin     = r_lfsr[0];

  // Dither LFSR, stepped once per sample
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= 16'hACE1;
    end else if (en) begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
    end
  end
`else
  assign w_cin = 1'b0;
`endif

  // Handshake state register; ready is registered from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_frac_ready <= 1'b1;
    end else begin
      r_state      <= w_state_next;
      r_frac_ready <= (w_state_next == ST_IDLE);
    end
  end

  // Handshake next-state: capture in IDLE, apply on the next sample in PEND
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_apply      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (frac_valid) begin
          w_capture    = 1'b1;
          w_state_next = ST_PEND;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_PEND: begin
        if (en) begin
          w_apply      = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_PEND;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Pending and active fractional words; active only moves on a sample edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend        <= {N{1'b0}};
      r_frac_active <= {N{1'b0}};
    end else begin
      if (w_capture) r_pend <= frac_in;
      if (w_apply)   r_frac_active <= r_pend;
    end
  end

  // Accumulator cascade and carry recombination, d_k = c_k + d_(k+1) - d_(k+1)_prev
  always_comb begin
    for (int k = 0; k < ORDER; k++) begin
      w_sum[k] = {(N+1){1'b0}};
      w_d[k]   = {CW{1'b0}};
    end
    w_sum[0] = {1'b0, r_frac_active} + {1'b0, r_acc[0]} + {{N{1'b0}}, w_cin};
    for (int k = 1; k < ORDER; k++) begin
      w_sum[k] = {1'b0, w_sum[k-1][N-1:0]} + {1'b0, r_acc[k]};
    end
    w_d[ORDER-1] = carry_ext(w_sum[ORDER-1][N]);
    for (int k = ORDER - 2; k >= 0; k--) begin
      w_d[k] = carry_ext(w_sum[k][N]) + w_d[k+1] - r_dprev[k+1];
    end
  end

  // Sample register: everything advances together on en, y_valid pulses once
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < ORDER; k++) begin
        r_acc[k]   <= {N{1'b0}};
        r_dprev[k] <= {CW{1'b0}};
      end
      r_y       <= {OUT_W{1'b0}};
      r_y_valid <= 1'b0;
    end else if (en) begin
      for (int k = 0; k < ORDER; k++) begin
        r_acc[k] <= w_sum[k][N-1:0];
      end
      for (int k = 1; k < ORDER; k++) begin
        r_dprev[k] <= w_d[k];
      end
      r_y       <= w_d[0][OUT_W-1:0];
      r_y_valid <= 1'b1;
    end else begin
      r_y_valid <= 1'b0;
    end
  end

  assign frac_ready  = r_frac_ready;
  assign frac_active = r_frac_active;
  assign y           = r_y;
  assign y_valid     = r_y_valid;

endmodule

// File: tb/tb_mash_dsm_core.sv
// Directed bench for mash_dsm_core: ORDER=3 and ORDER=1 instances (N=8) share stimulus.
`timescale 1ns/1ps

module tb_mash_dsm_core;

  logic       clk;
  logic       reset;
  logic       en;
  logic [7:0] frac_in;
  logic       frac_valid;

  logic              ready3, yv3, ready1, yv1;
  logic [7:0]        active3, active1;
  logic signed [3:0] y3, y1;

  int n_checks;
  int n_fail;

  mash_dsm_core #(.N(8), .ORDER(3), .OUT_W(4)) dut3 (
    .clk(clk), .reset(reset), .en(en), .frac_in(frac_in), .frac_valid(frac_valid),
    .frac_ready(ready3), .frac_active(active3), .y(y3), .y_valid(yv3)
  );

  mash_dsm_core #(.N(8), .ORDER(1), .OUT_W(4)) dut1 (
    .clk(clk), .reset(reset), .en(en), .frac_in(frac_in), .frac_valid(frac_valid),
    .frac_ready(ready1), .frac_active(active1), .y(y1), .y_valid(yv1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; frac_valid = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic load_word(input logic [7:0] w);
    frac_in = w; frac_valid = 1'b1; en = 1'b0;
    step();
    frac_valid = 1'b0; en = 1'b1;
    step();
    en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; frac_valid = 1'b1; frac_in = 8'hFF;
    step();
    step();
    n_checks++;
    if (y3 !== 4'sd0 || yv3 !== 1'b0 || active3 !== 8'h00 || ready3 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset3: y=%0d yv=%b act=%h rdy=%b expected 0 0 00 1", y3, yv3, active3, ready3);
    end
    n_checks++;
    if (y1 !== 4'sd0 || yv1 !== 1'b0 || active1 !== 8'h00 || ready1 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset1: y=%0d yv=%b act=%h rdy=%b expected 0 0 00 1", y1, yv1, active1, ready1);
    end
    reset = 1'b0; en = 1'b0; frac_valid = 1'b0;
  endtask

  task automatic test_zero();
    do_reset();
    load_word(8'h00);
    en = 1'b1;
    for (int i = 0; i < 512; i++) begin
      step();
      n_checks++;
      if (yv3 !== 1'b1 || y3 !== 4'sd0) begin
        n_fail++;
        $display("FAIL zero_y[%0d]: y=%0d yv=%b expected 0 1", i, y3, yv3);
      end
    end
    en = 1'b0;
    n_checks++;
    if (active3 !== 8'h00) begin
      n_fail++;
      $display("FAIL zero_active: got %h expected 00", active3);
    end
  endtask

  task automatic test_order1_half();
    logic signed [3:0] e;
    do_reset();
    load_word(8'd128);
    n_checks++;
    if (active1 !== 8'd128) begin
      n_fail++;
      $display("FAIL half_active: got %0d expected 128", active1);
    end
    en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      e = (i % 2 == 1) ? 4'sd1 : 4'sd0;
      n_checks++;
      if (yv1 !== 1'b1 || y1 !== e) begin
        n_fail++;
        $display("FAIL half_y[%0d]: y=%0d yv=%b expected %0d 1", i, y1, yv1, e);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_max_frac();
    logic signed [3:0] e;
    do_reset();
    load_word(8'hFF);
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      e = (i == 0) ? 4'sd0 : 4'sd1;
      n_checks++;
      if (y1 !== e) begin
        n_fail++;
        $display("FAIL maxfrac_y[%0d]: got %0d expected %0d", i, y1, e);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_mash3();
    logic signed [3:0] exp3 [8];
    int sum;
    int v;
    exp3[0] = 4'sd0;  exp3[1] = 4'sd1; exp3[2] = -4'sd1; exp3[3] = 4'sd2;
    exp3[4] = -4'sd2; exp3[5] = 4'sd3; exp3[6] = -4'sd2; exp3[7] = 4'sd1;
    do_reset();
    load_word(8'd64);
    en = 1'b1;
    sum = 0;
    for (int i = 0; i < 1024; i++) begin
      step();
      if (i < 8) begin
        n_checks++;
        if (y3 !== exp3[i]) begin
          n_fail++;
          $display("FAIL mash3_seq[%0d]: got %0d expected %0d", i, y3, exp3[i]);
        end
      end
      v = int'(y3);
      n_checks++;
      if ($isunknown(y3) || v < -3 || v > 4) begin
        n_fail++;
        $display("FAIL mash3_range[%0d]: got %0d expected -3..4", i, y3);
      end
      sum += v;
    end
    en = 1'b0;
    n_checks++;
    if (sum < 255 || sum > 258) begin
      n_fail++;
      $display("FAIL mash3_sum: got %0d expected 255..258", sum);
    end
  endtask

  task automatic test_handshake();
    logic signed [3:0] e;
    do_reset();
    frac_in = 8'h40; frac_valid = 1'b1; en = 1'b1;
    step();
    n_checks++;
    if (ready3 !== 1'b0 || active3 !== 8'h00) begin
      n_fail++;
      $display("FAIL hs_capture: rdy=%b act=%h expected 0 00", ready3, active3);
    end
    frac_in = 8'h80; frac_valid = 1'b1; en = 1'b0;
    step();
    n_checks++;
    if (ready3 !== 1'b0 || active3 !== 8'h00) begin
      n_fail++;
      $display("FAIL hs_pend: rdy=%b act=%h expected 0 00", ready3, active3);
    end
    frac_valid = 1'b0; en = 1'b1;
    step();
    n_checks++;
    if (ready3 !== 1'b1 || active3 !== 8'h40) begin
      n_fail++;
      $display("FAIL hs_apply: rdy=%b act=%h expected 1 40", ready3, active3);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      e = (i == 3) ? 4'sd1 : 4'sd0;
      n_checks++;
      if (y1 !== e) begin
        n_fail++;
        $display("FAIL hs_old_word_y[%0d]: got %0d expected %0d", i, y1, e);
      end
    end
    en = 1'b0;
    n_checks++;
    if (active3 !== 8'h40 || active1 !== 8'h40) begin
      n_fail++;
      $display("FAIL hs_no_overwrite: act3=%h act1=%h expected 40 40", active3, active1);
    end
  endtask

  task automatic test_en_gating();
    logic              en_pat [5];
    logic signed [3:0] y_exp  [5];
    logic              v_exp  [5];
    en_pat[0] = 1'b1; en_pat[1] = 1'b1; en_pat[2] = 1'b0; en_pat[3] = 1'b0; en_pat[4] = 1'b1;
    y_exp[0]  = 4'sd0; y_exp[1] = 4'sd1; y_exp[2] = 4'sd1; y_exp[3] = 4'sd1; y_exp[4] = -4'sd1;
    v_exp[0]  = 1'b1; v_exp[1] = 1'b1; v_exp[2] = 1'b0; v_exp[3] = 1'b0; v_exp[4] = 1'b1;
    do_reset();
    load_word(8'd64);
    for (int i = 0; i < 5; i++) begin
      en = en_pat[i];
      step();
      n_checks++;
      if (y3 !== y_exp[i] || yv3 !== v_exp[i]) begin
        n_fail++;
        $display("FAIL engate[%0d]: y=%0d yv=%b expected %0d %b", i, y3, yv3, y_exp[i], v_exp[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_word(8'd64);
    en = 1'b1;
    repeat (5) step();
    frac_in = 8'h80; frac_valid = 1'b1; en = 1'b0;
    step();
    n_checks++;
    if (ready3 !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_pend: rdy=%b expected 0", ready3);
    end
    reset = 1'b1; en = 1'b1; frac_valid = 1'b1;
    step();
    n_checks++;
    if (y3 !== 4'sd0 || yv3 !== 1'b0 || active3 !== 8'h00 || ready3 !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_state: y=%0d yv=%b act=%h rdy=%b expected 0 0 00 1", y3, yv3, active3, ready3);
    end
`ifdef MASH_DSM_DITHER_EN
    n_checks++;
    if (dut3.r_lfsr !== 16'hACE1) begin
      n_fail++;
      $display("FAIL rstmid_lfsr: got %h expected ace1", dut3.r_lfsr);
    end
`endif
    reset = 1'b0; frac_valid = 1'b0; en = 1'b1;
    repeat (4) step();
    en = 1'b0;
    n_checks++;
    if (active3 !== 8'h00 || y3 !== 4'sd0 || ready3 !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_discard: act=%h y=%0d rdy=%b expected 00 0 1", active3, y3, ready3);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b1; en = 1'b0; frac_in = 8'h00; frac_valid = 1'b0;
    test_reset();
    test_zero();
    test_order1_half();
    test_max_frac();
    test_mash3();
    test_handshake();
    test_en_gating();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
